// File: rtl/cla_pkg.sv
// ============================================================================
// Package : cla_pkg
// Brief   : Shared width, latency and operand type for the 4-bit CLA slice.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package cla_pkg;

  localparam int CLA_W       = 4;
  localparam int CLA_LATENCY = 2;

  typedef logic [CLA_W-1:0] nibble_t;

endpackage : cla_pkg

`default_nettype wire

// File: rtl/cla4_comb.sv
// ============================================================================
// Module : cla4_comb
// Brief  : Combinational 4-bit carry-lookahead core; also provides the group
//          propagate/generate terms needed to cascade slices.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module cla4_comb
  import cla_pkg::*;
(
  input  nibble_t a,
  input  nibble_t b,
  input  logic    cin,
  output nibble_t sum,
  output logic    cout,
  output logic    pg,
  output logic    gg
);

  nibble_t    w_g;
  nibble_t    w_p;
  logic [4:0] w_c;

  for (genvar i = 0; i < CLA_W; i++) begin : g_bit
    assign w_g[i] = a[i] & b[i];
    assign w_p[i] = a[i] ^ b[i];
    assign sum[i] = w_p[i] ^ w_c[i];
  end : g_bit

  // Every carry is a flat sum-of-products of g/p and cin; no carry feeds another.
  assign w_c[0] = cin;
  assign w_c[1] = w_g[0]
                | (w_p[0] & cin);
  assign w_c[2] = w_g[1]
                | (w_p[1] & w_g[0])
                | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2]
                | (w_p[2] & w_g[1])
                | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);
  assign w_c[4] = w_g[3]
                | (w_p[3] & w_g[2])
                | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

  assign cout = w_c[4];

  // Group terms are independent of cin so a higher-level lookahead can use them.
  assign pg = &w_p;
  assign gg = w_g[3]
            | (w_p[3] & w_g[2])
            | (w_p[3] & w_p[2] & w_g[1])
            | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

endmodule : cla4_comb

`default_nettype wire

// File: rtl/clad_cla4.sv
// ============================================================================
// Module : clad_cla4
// Brief  : 4-bit CLA adder with registered operands and registered result,
//          two-cycle latency, one result per clock.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module clad_cla4
  import cla_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  nibble_t r_a_q;
  nibble_t r_b_q;
  logic    r_cin_q;

  nibble_t w_sum;
  logic    w_cout;
  logic    w_pg;
  logic    w_gg;
  logic    w_cascade_unused;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a_q   <= '0;
      r_b_q   <= '0;
      r_cin_q <= 1'b0;
    end else begin
      r_a_q   <= a;
      r_b_q   <= b;
      r_cin_q <= cin;
    end
  end

  cla4_comb u_cla4_comb (
    .a    (r_a_q),
    .b    (r_b_q),
    .cin  (r_cin_q),
    .sum  (w_sum),
    .cout (w_cout),
    .pg   (w_pg),
    .gg   (w_gg)
  );

  // Group terms are kept for a future cascaded build; nothing consumes them here.
  assign w_cascade_unused = w_pg ^ w_gg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s    <= '0;
      cout <= 1'b0;
    end else begin
      s    <= w_sum;
      cout <= w_cout;
    end
  end

endmodule : clad_cla4

`default_nettype wire

// File: tb/tb_clad_cla4.sv
// ============================================================================
// Module : tb_clad_cla4
// Brief  : Self-checking bench for clad_cla4 against an arithmetic reference.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_clad_cla4;
  import cla_pkg::*;

  logic       clk;
  logic       rst;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [3:0] s;
  logic       cout;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  clad_cla4 dut (
    .clk  (clk),
    .rst  (rst),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .s    (s),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: each edge retires the oldest pending sum and queues a+b+cin.
  logic [4:0] model_q[$];
  logic [4:0] model_out = 5'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_q = {};
      for (int k = 0; k < CLA_LATENCY - 1; k++) model_q.push_back(5'd0);
      model_out = 5'd0;
    end else begin
      model_out = model_q.pop_front();
      model_q.push_back(5'((int'(a) + int'(b) + int'(cin)) % 32));
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_assert++;
      if ({cout, s} !== model_out) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t: got {cout,s}=%b required %b", $time, {cout, s}, model_out);
      end
    end
  end

  task automatic drive(input logic [3:0] ta, input logic [3:0] tb_v, input logic tc);
    a   = ta;
    b   = tb_v;
    cin = tc;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_lit(input string name, input logic [4:0] req);
    n_assert++;
    if ({cout, s} !== req) begin
      n_fail++;
      $display("FAIL %s: got {cout,s}=%b required %b", name, {cout, s}, req);
    end
    n_assert++;
    if (model_out !== req) begin
      n_fail++;
      $display("FAIL %s_model: model gives %b required %b", name, model_out, req);
    end
  endtask

  typedef struct {
    logic [3:0] va;
    logic [3:0] vb;
    logic       vc;
    logic [4:0] res;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{4'd1,  4'd2,  1'b1, 5'b0_0100};
    vecs[1] = '{4'd3,  4'd5,  1'b0, 5'b0_1000};
    vecs[2] = '{4'd10, 4'd5,  1'b0, 5'b0_1111};
    vecs[3] = '{4'd10, 4'd12, 1'b1, 5'b1_0111};
    vecs[4] = '{4'd15, 4'd1,  1'b0, 5'b1_0000};
    vecs[5] = '{4'd15, 4'd15, 1'b0, 5'b1_1110};
    vecs[6] = '{4'd15, 4'd15, 1'b1, 5'b1_1111};

    // Reset asserted with non-zero operands, checked before any clock edge.
    rst = 1'b0;
    drive(4'hF, 4'hF, 1'b1);
    #1 rst = 1'b1;
    #1 check_lit("reset_async", 5'd0);
    chk_en = 1'b1;
    step();
    step();
    check_lit("reset_hold", 5'd0);

    rst = 1'b0;
    drive(4'd0, 4'd0, 1'b0);
    step();
    step();
    check_lit("zero_add", 5'd0);

    // One vector at a time, two edges after apply.
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].va, vecs[i].vb, vecs[i].vc);
      step();
      drive(4'd0, 4'd0, 1'b0);
      step();
      check_lit($sformatf("single_%0d", i), vecs[i].res);
    end

    // Back-to-back: result i must appear exactly one edge after result i-1.
    for (int i = 0; i < 8; i++) begin
      if (i < 7) drive(vecs[i].va, vecs[i].vb, vecs[i].vc);
      else       drive(4'd0, 4'd0, 1'b0);
      step();
      if (i >= 1) check_lit($sformatf("stream_%0d", i - 1), vecs[i - 1].res);
    end

    for (int i = 0; i < 512; i++) begin
      drive(4'(i >> 5), 4'(i >> 1), 1'(i));
      step();
    end
    drive(4'd0, 4'd0, 1'b0);
    step();
    step();

    // 15+1 captured in the input stage, then reset lands mid-cycle.
    drive(4'd15, 4'd1, 1'b0);
    step();
    #1 rst = 1'b1;
    #1 check_lit("reset_midstream", 5'd0);
    #1 rst = 1'b0;
    drive(4'd3, 4'd4, 1'b0);
    step();
    check_lit("discard_inflight", 5'd0);
    drive(4'd0, 4'd0, 1'b0);
    step();
    check_lit("post_reset_first", 5'd7);
    step();
    check_lit("post_reset_idle", 5'd0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_clad_cla4

`default_nettype wire
